// File: rtl/sqrt_odd_step_s5.sv
// Stage 5 of the pipelined square root: odd-sum root finder driving the stage-4 square register.
// Optional remainder output is enabled by defining SQRT_REMAINDER_EN.
module sqrt_odd_step_s5 #(
    parameter int unsigned A_WIDTH  = 12,
    parameter int unsigned SQ_WIDTH = A_WIDTH + 1,
    parameter int unsigned D_WIDTH  = A_WIDTH / 2 + 2,
    parameter int unsigned R_WIDTH  = A_WIDTH / 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [A_WIDTH-1:0]  a_in,
    input  logic [SQ_WIDTH-1:0] square_in,
    output logic [SQ_WIDTH-1:0] sq_next,
    output logic                sq_enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [R_WIDTH-1:0]  root
`ifdef SQRT_REMAINDER_EN
    ,
    output logic [R_WIDTH:0]    rem
`endif
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e               state_q, state_d;
    logic [D_WIDTH-1:0]   delta_q, delta_d;
    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [R_WIDTH-1:0]   root_q, root_d;
    logic                 out_valid_q, out_valid_d;
    logic                 continue_iter;

    // Square still fits under the operand: keep adding the next odd number.
    assign continue_iter = (square_in <= SQ_WIDTH'(a_q));

    always_comb begin
        state_d     = state_q;
        delta_d     = delta_q;
        a_d         = a_q;
        root_d      = root_q;
        out_valid_d = out_valid_q;
        sq_next     = SQ_WIDTH'(1);
        sq_enable   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d       = a_in;
                    delta_d   = D_WIDTH'(3);
                    sq_enable = 1'b1;
                    state_d   = StIter;
                end
            end
            StIter: begin
                if (continue_iter) begin
                    sq_next   = square_in + SQ_WIDTH'(delta_q);
                    sq_enable = 1'b1;
                    delta_d   = delta_q + D_WIDTH'(2);
                end else begin
                    root_d      = R_WIDTH'((delta_q >> 1) - D_WIDTH'(1));
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over everything, including an accept in the same cycle.
        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            sq_enable   = 1'b0;
            a_d         = a_q;
            delta_d     = delta_q;
            root_d      = root_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            delta_q     <= D_WIDTH'(3);
            a_q         <= '0;
            root_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            delta_q     <= delta_d;
            a_q         <= a_d;
            root_q      <= root_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SQRT_REMAINDER_EN
    logic [R_WIDTH:0]  rem_q, rem_d;
    logic [SQ_WIDTH-1:0] prev_square;

    // square_in - delta + 2 recovers root^2 (the last square not exceeding a).
    assign prev_square = square_in - SQ_WIDTH'(delta_q) + SQ_WIDTH'(2);

    always_comb begin
        rem_d = rem_q;
        if (state_q == StIter && !continue_iter && !flush) begin
            rem_d = (R_WIDTH + 1)'(SQ_WIDTH'(a_q) - prev_square);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign root      = root_q;

endmodule

// File: tb/tb_sqrt_odd_step_s5.sv
// Bench for sqrt_odd_step_s5: vector table, random operands against an integer sqrt model,
// plus flush and mid-iteration reset sequences. Define SQRT_REMAINDER_EN to also check rem.
module tb_sqrt_odd_step_s5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] a_in = '0;
    logic [12:0] square_in;
    logic [12:0] sq_next;
    logic        sq_enable;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  root;
`ifdef SQRT_REMAINDER_EN
    logic [6:0]  rem;
`endif

    int checks = 0;
    int errors = 0;

    // Stand-in for the stage-4 square register.
    logic [12:0] sq_reg = '0;
    always @(posedge clock) if (sq_enable) sq_reg <= sq_next;
    assign square_in = sq_reg;

    always #5 clock = ~clock;

    sqrt_odd_step_s5 dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .square_in (square_in),
        .sq_next   (sq_next),
        .sq_enable (sq_enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root)
`ifdef SQRT_REMAINDER_EN
        ,
        .rem       (rem)
`endif
    );

    typedef struct {
        int a;
        int exp_root;
        int exp_rem;
        int hold;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_root(input int a);
        int r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    task automatic run_op(input int a, input int exp_root, input int exp_rem, input int hold);
        int lat;
        int en;
        int peak;
        int r0;
        bit stable;
        @(negedge clock);
        in_valid = 1'b1;
        a_in     = 12'(a);
        #1;
        check("in_ready_idle", int'(in_ready), 1);
        lat  = 0;
        en   = 0;
        peak = 0;
        while (lat < 200) begin
            if (sq_enable) begin
                en++;
                if (int'(sq_next) > peak) peak = int'(sq_next);
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
            in_valid = 1'b0;
            a_in     = 12'($urandom);
            #1;
            if (out_valid) break;
        end
        check("out_valid_seen", int'(out_valid), 1);
        check("latency", lat, exp_root + 2);
        check("root", int'(root), exp_root);
        check("sq_enable_cycles", en, exp_root + 1);
        check("peak_sq_next", peak, (exp_root + 1) * (exp_root + 1));
        check("in_ready_busy", int'(in_ready), 0);
`ifdef SQRT_REMAINDER_EN
        check("rem", int'(rem), exp_rem);
`else
        if (exp_rem < 0) check("rem_model", exp_rem, 0);
`endif
        r0     = int'(root);
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            if (!out_valid || int'(root) != r0 || in_ready) stable = 1'b0;
        end
        check("done_hold_stable", int'(stable), 1);
        // Offer a new operand during the handshake cycle; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check("handshake_sq_enable", int'(sq_enable), 0);
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("out_valid_cleared", int'(out_valid), 0);
        check("no_accept_on_handshake", int'(in_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 0, 1};
        vecs[1] = '{1, 1, 0, 0};
        vecs[2] = '{4, 2, 0, 2};
        vecs[3] = '{15, 3, 6, 10};
        vecs[4] = '{16, 4, 0, 0};
        vecs[5] = '{4095, 63, 126, 3};
        vecs[6] = '{100, 10, 0, 1};
        vecs[7] = '{2000, 44, 64, 0};

        // Reset values
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_root", int'(root), 0);
        check("rst_sq_enable", int'(sq_enable), 0);
        check("rst_sq_next", int'(sq_next), 1);
`ifdef SQRT_REMAINDER_EN
        check("rst_rem", int'(rem), 0);
`endif
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].exp_root, vecs[i].exp_rem, vecs[i].hold);
        end

        for (int i = 0; i < 20; i++) begin
            int a;
            int r;
            a = int'($urandom_range(0, 4095));
            r = model_root(a);
            run_op(a, r, a - r * r, int'($urandom_range(0, 3)));
        end

        // Flush during the accept cycle discards the operand
        @(negedge clock);
        in_valid = 1'b1;
        a_in     = 12'd50;
        flush    = 1'b1;
        #1;
        check("flush_accept_sq_enable", int'(sq_enable), 0);
        @(negedge clock);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_accept_in_ready", int'(in_ready), 1);
        check("flush_accept_sq_enable_after", int'(sq_enable), 0);

        // Flush at ITER cycle 3 of a=100
        begin
            bit saw_valid = 1'b0;
            @(negedge clock);
            in_valid = 1'b1;
            a_in     = 12'd100;
            for (int c = 0; c < 3; c++) begin
                @(posedge clock);
                @(negedge clock);
                in_valid = 1'b0;
                #1;
                if (out_valid) saw_valid = 1'b1;
            end
            flush = 1'b1;
            #1;
            check("flush_iter_sq_enable", int'(sq_enable), 0);
            @(posedge clock);
            @(negedge clock);
            flush = 1'b0;
            #1;
            if (out_valid) saw_valid = 1'b1;
            check("flush_iter_in_ready", int'(in_ready), 1);
            check("flush_iter_never_valid", int'(saw_valid), 0);
        end
        run_op(100, 10, 0, 0);

        // Asynchronous reset mid-ITER of a=2000
        @(negedge clock);
        in_valid = 1'b1;
        a_in     = 12'd2000;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_in_ready", int'(in_ready), 1);
        check("async_rst_out_valid", int'(out_valid), 0);
        @(negedge clock);
        reset = 1'b1;
        run_op(2000, 44, 64, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
